// File: rtl/fast_multiplier_if.sv
`default_nettype none
// ============================================================================
//  Module   : fast_multiplier_if
//  Brief    : Operand / product bundle for the single-cycle 32x32 multiplier.
//  Revision : 1.0  initial release
// ============================================================================
interface fast_multiplier_if;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        is_signed;
  logic        in_valid;
  logic [63:0] product;
  logic        out_valid;

  // Requester side: presents operands, observes the registered result
  modport master (
    output multiplicand, multiplier, is_signed, in_valid,
    input  product, out_valid
  );

  // Multiplier side: consumes operands, drives the registered result
  modport slave (
    input  multiplicand, multiplier, is_signed, in_valid,
    output product, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/fast_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : fast_multiplier
//  Brief    : 32x32 -> 64 signed/unsigned multiplier, radix-4 Booth partial
//             products, carry-save reduction tree, one final adder, 1-cycle
//             latency at full throughput.
//  Revision : 1.0  initial release
// ============================================================================
module fast_multiplier (
  input  wire              clk,
  input  wire              rst,
  fast_multiplier_if.slave bus
);

  localparam int NUM_PP   = 17;  // Booth digits of a 33-bit operand
  localparam int NUM_ROWS = 18;  // partial products plus the carry-in row
  localparam int NUM_LVL  = 6;   // 18->12->8->6->4->3->2 rows

  // Both modes share one signed datapath: a 33-bit extension makes an
  // unsigned operand look like a non-negative signed one.
  logic [32:0] w_a_ext;
  logic [32:0] w_b_ext;
  logic [63:0] w_m;
  logic [63:0] w_m2;
  logic [34:0] w_bx;

  assign w_a_ext = {bus.is_signed & bus.multiplicand[31], bus.multiplicand};
  assign w_b_ext = {bus.is_signed & bus.multiplier[31],   bus.multiplier};
  assign w_m     = {{31{w_a_ext[32]}}, w_a_ext};
  assign w_m2    = {w_m[62:0], 1'b0};
  // Implicit zero below bit 0 and one extra sign bit so digit 16 is complete
  assign w_bx    = {w_b_ext[32], w_b_ext, 1'b0};

  logic [63:0]       w_pp [0:NUM_PP-1];
  logic [NUM_PP-1:0] w_neg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PP; gi++) begin : g_booth
      logic [2:0]  w_trip;
      logic        w_one;
      logic        w_two;
      logic [63:0] w_sel;

      assign w_trip = w_bx[2*gi+2 -: 3];
      assign w_one  = w_trip[0] ^ w_trip[1];
      assign w_two  = (w_trip == 3'b011) || (w_trip == 3'b100);
      // 3'b111 encodes -0, which must not inject a stray carry
      assign w_neg[gi] = w_trip[2] & ~(w_trip[1] & w_trip[0]);
      assign w_sel  = w_one ? w_m : (w_two ? w_m2 : 64'd0);
      // Full 64-bit sign extension keeps the low 64 bits of the sum exact;
      // invert before shifting so vacated low bits stay zero.
      assign w_pp[gi] = (w_neg[gi] ? ~w_sel : w_sel) << (2*gi);
    end
  endgenerate

  // Gather the two's-complement +1 of every negated row into one extra row
  logic [63:0] w_cin;
  always_comb begin
    w_cin = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      w_cin[2*i] = w_neg[i];
    end
  end

  // Wallace-style reduction: every level compresses row triples with 3:2
  // counters and passes leftover rows straight through.
  logic [63:0] w_lvl [0:NUM_ROWS-1];
  logic [63:0] w_nxt [0:NUM_ROWS-1];
  int          w_cnt;
  always_comb begin
    for (int r = 0; r < NUM_PP; r++) begin
      w_lvl[r] = w_pp[r];
    end
    w_lvl[NUM_ROWS-1] = w_cin;
    for (int r = 0; r < NUM_ROWS; r++) begin
      w_nxt[r] = '0;
    end
    w_cnt = NUM_ROWS;
    for (int l = 0; l < NUM_LVL; l++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        w_nxt[r] = '0;
      end
      for (int g = 0; g < NUM_ROWS/3; g++) begin
        if (g < w_cnt/3) begin
          w_nxt[2*g]   = w_lvl[3*g] ^ w_lvl[3*g+1] ^ w_lvl[3*g+2];
          w_nxt[2*g+1] = ((w_lvl[3*g]   & w_lvl[3*g+1]) |
                          (w_lvl[3*g]   & w_lvl[3*g+2]) |
                          (w_lvl[3*g+1] & w_lvl[3*g+2])) << 1;
        end
      end
      for (int r = 0; r < 2; r++) begin
        if (r < w_cnt % 3) begin
          w_nxt[2*(w_cnt/3)+r] = w_lvl[3*(w_cnt/3)+r];
        end
      end
      w_cnt = (w_cnt/3)*2 + (w_cnt % 3);
      for (int r = 0; r < NUM_ROWS; r++) begin
        w_lvl[r] = w_nxt[r];
      end
    end
  end

  // Final carry-propagate add; anything above bit 63 is dropped
  logic [63:0] product_d;
  assign product_d = w_lvl[0] + w_lvl[1];

  logic [63:0] product_q;
  logic        out_valid_q;

  // Result register: capture on valid, hold otherwise, clear on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      product_q   <= '0;
      out_valid_q <= 1'b0;
    end else if (bus.in_valid) begin
      product_q   <= product_d;
      out_valid_q <= 1'b1;
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.product   = product_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fast_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fast_multiplier
//  Brief    : Self-checking bench for fast_multiplier: directed vector table,
//             hold / reset sequences and a random back-to-back stream checked
//             against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fast_multiplier;

  localparam int N_RANDOM = 20000;

  logic clk;
  logic rst;
  fast_multiplier_if u_if ();

  fast_multiplier u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  // Reference: exact product from plain wide arithmetic
  function automatic logic [63:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0]        ua;
    logic [63:0]        ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    return s ? 64'(sa * sb) : 64'(ua * ub);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic act_v, input logic [63:0] exp,
                     input logic exp_v);
    n_total++;
    if (act === exp && act_v === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: product=%h out_valid=%b, expected product=%h out_valid=%b",
               name, act, act_v, exp, exp_v);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic v);
    u_if.multiplicand = a;
    u_if.multiplier   = b;
    u_if.is_signed    = s;
    u_if.in_valid     = v;
  endtask

  vec_t        tbl [14];
  logic [63:0] exp_q [$];
  logic [63:0] last;
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    tbl[0]  = '{32'd10,        32'hFFFFFFFF, 1'b1, 64'hFFFFFFFFFFFFFFF6};
    tbl[1]  = '{32'd10,        32'hFFFFFFFF, 1'b0, 64'h00000009FFFFFFF6};
    tbl[2]  = '{32'hFFFFFFFF,  32'hFFFFFFFF, 1'b1, 64'h0000000000000001};
    tbl[3]  = '{32'hFFFFFFFF,  32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001};
    tbl[4]  = '{32'h80000000,  32'd6,        1'b1, 64'hFFFFFFFD00000000};
    tbl[5]  = '{32'h80000000,  32'd6,        1'b0, 64'h0000000300000000};
    tbl[6]  = '{32'h80000000,  32'd14,       1'b1, 64'hFFFFFFF900000000};
    tbl[7]  = '{32'h80000000,  32'd14,       1'b0, 64'h0000000700000000};
    tbl[8]  = '{32'd0,         32'd0,        1'b1, 64'd0};
    tbl[9]  = '{32'd0,         32'd0,        1'b0, 64'd0};
    tbl[10] = '{32'd9,         32'd10,       1'b1, 64'd90};
    tbl[11] = '{32'd9,         32'd10,       1'b0, 64'd90};
    tbl[12] = '{32'h80000000,  32'h80000000, 1'b1, 64'h4000000000000000};
    tbl[13] = '{32'h7FFFFFFF,  32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF00000001};

    // Reset with a valid operation presented: it must be discarded
    rst = 1'b1;
    drive(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", u_if.product, u_if.out_valid, 64'd0, 1'b0);

    // Directed vectors, one per cycle, 1-cycle latency
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].s, 1'b1);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i), u_if.product, u_if.out_valid, tbl[i].exp, 1'b1);
      @(negedge clk);
    end

    // Idle cycle with changed operands and mode: product holds
    last = tbl[13].exp;
    drive(32'hFFFFFFFF, 32'h00000003, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("hold_idle", u_if.product, u_if.out_valid, last, 1'b0);
    @(negedge clk);
    u_if.is_signed = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_mode_flip", u_if.product, u_if.out_valid, last, 1'b0);
    @(negedge clk);

    // Random back-to-back stream, each pair in both modes
    for (int k = 0; k <= 2*N_RANDOM; k++) begin
      if (k > 0) begin
        chk("random", u_if.product, u_if.out_valid, exp_q.pop_front(), 1'b1);
      end
      if (k < 2*N_RANDOM) begin
        if (k % 2 == 0) begin
          ra = $urandom();
          rb = $urandom();
        end
        drive(ra, rb, 1'(k % 2 == 0), 1'b1);
        exp_q.push_back(ref_mul(ra, rb, 1'(k % 2 == 0)));
      end else begin
        u_if.in_valid = 1'b0;
      end
      @(negedge clk);
    end

    // Reset in the middle of a stream
    drive(32'hFFFF0001, 32'h0000FFFF, 1'b0, 1'b1);
    @(negedge clk);
    chk("pre_reset_op", u_if.product, u_if.out_valid,
        ref_mul(32'hFFFF0001, 32'h0000FFFF, 1'b0), 1'b1);
    rst = 1'b1;
    drive(32'h00000005, 32'h00000007, 1'b1, 1'b1);
    @(negedge clk);
    chk("mid_reset", u_if.product, u_if.out_valid, 64'd0, 1'b0);
    rst = 1'b0;
    drive(32'hFFFFFFFD, 32'h00000007, 1'b1, 1'b1);
    @(negedge clk);
    chk("post_reset_signed", u_if.product, u_if.out_valid,
        64'hFFFFFFFFFFFFFFEB, 1'b1);
    drive(32'hFFFFFFFD, 32'h00000007, 1'b0, 1'b1);
    @(negedge clk);
    chk("post_reset_unsigned", u_if.product, u_if.out_valid,
        64'h00000006FFFFFFEB, 1'b1);
    u_if.in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", u_if.product, u_if.out_valid,
        64'h00000006FFFFFFEB, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
